// File: rtl/pkt_dispatcher_if.sv
// Stream bundle between the packet source, the dispatcher and its matcher lanes.
// The dispatcher uses the slave view; whoever feeds it and consumes the lanes uses master.
interface pkt_dispatcher_if #(
   parameter int NUM_LANES = 2,
   parameter int DATA_W    = 8
);
   logic [DATA_W-1:0]           in_data;
   logic                        in_valid;
   logic                        in_sop;
   logic                        in_eop;
   logic                        in_ready;
   logic [NUM_LANES*DATA_W-1:0] lane_data;
   logic [NUM_LANES-1:0]        lane_valid;
   logic [NUM_LANES-1:0]        lane_sop;
   logic [NUM_LANES-1:0]        lane_eop;
   logic [NUM_LANES-1:0]        lane_stall;

   modport master (
      output in_data, in_valid, in_sop, in_eop,
      input  in_ready,
      input  lane_data, lane_valid, lane_sop, lane_eop,
      output lane_stall
   );

   modport slave (
      input  in_data, in_valid, in_sop, in_eop,
      output in_ready,
      output lane_data, lane_valid, lane_sop, lane_eop,
      input  lane_stall
   );
endinterface

// File: rtl/pkt_dispatcher.sv
// Round-robin packet dispatcher: locks each incoming packet to one free matcher lane
// and forwards it through a one-entry register per lane.
module pkt_dispatcher #(
   parameter int NUM_LANES = 2,
   parameter int DATA_W    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   pkt_dispatcher_if.slave              bus,
   output logic                         busy,
   output logic [$clog2(NUM_LANES)-1:0] active_lane,
   output logic [31:0]                  pkt_count,
   output logic [15:0]                  drop_count
);

   localparam int LW = $clog2(NUM_LANES);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                           state;
   state_t                           state_nxt;
   logic [LW-1:0]                    ptr;
   logic [LW-1:0]                    sel_lane;
   logic                             sel_found;
   logic [LW:0]                      cand;
   logic [NUM_LANES-1:0]             lane_v;
   logic [NUM_LANES-1:0]             lane_s;
   logic [NUM_LANES-1:0]             lane_e;
   logic [NUM_LANES-1:0][DATA_W-1:0] lane_d;
   logic [NUM_LANES-1:0]             lane_xfer;
   logic [NUM_LANES-1:0]             load;
   logic                             ready_c;
   logic                             accept;
   logic                             dispatch;
   logic                             drop;

   assign lane_xfer      = lane_v & ~bus.lane_stall;
   assign bus.lane_valid = lane_v;
   assign bus.lane_sop   = lane_s;
   assign bus.lane_eop   = lane_e;
   assign bus.lane_data  = lane_d;
   assign bus.in_ready   = ready_c;
   assign busy           = (state == BUSY);

   // Search starts just after the last dispatched lane and wraps, so the pointer lane is tried last.
   always_comb begin
      sel_found = 1'b0;
      sel_lane  = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_LANES; k++) begin
         cand = {1'b0, ptr} + (LW+1)'(k);
         if (cand >= (LW+1)'(NUM_LANES)) begin
            cand = cand - (LW+1)'(NUM_LANES);
         end
         if (!sel_found && !lane_v[cand[LW-1:0]] && !bus.lane_stall[cand[LW-1:0]]) begin
            sel_found = 1'b1;
            sel_lane  = cand[LW-1:0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ready_c   = 1'b0;
      accept    = 1'b0;
      dispatch  = 1'b0;
      drop      = 1'b0;
      load      = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (bus.in_sop) begin
                  ready_c = enable && sel_found;
               end else begin
                  ready_c = 1'b1;
               end
               accept = bus.in_valid && ready_c;
               if (accept) begin
                  if (bus.in_sop) begin
                     dispatch       = 1'b1;
                     load[sel_lane] = 1'b1;
                     if (!bus.in_eop) begin
                        state_nxt = BUSY;
                     end
                  end else begin
                     drop = 1'b1;
                  end
               end
            end
            BUSY: begin
               // The locked lane can take a new byte when empty or when its current byte leaves now.
               ready_c = !lane_v[active_lane] || !bus.lane_stall[active_lane];
               accept  = bus.in_valid && ready_c;
               if (accept) begin
                  load[active_lane] = 1'b1;
                  if (bus.in_eop) begin
                     state_nxt = IDLE;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Pointer resets to the last lane so the very first packet lands on lane 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr         <= LW'(NUM_LANES - 1);
         active_lane <= '0;
         pkt_count   <= '0;
         drop_count  <= '0;
      end else begin
         if (dispatch) begin
            ptr         <= sel_lane;
            active_lane <= sel_lane;
            pkt_count   <= pkt_count + 32'd1;
         end
         if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_v <= '0;
         lane_s <= '0;
         lane_e <= '0;
         lane_d <= '0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (load[i]) begin
               lane_v[i] <= 1'b1;
               lane_s[i] <= bus.in_sop;
               lane_e[i] <= bus.in_eop;
               lane_d[i] <= bus.in_data;
            end else if (lane_xfer[i]) begin
               lane_v[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pkt_dispatcher.sv
// Scoreboard bench for pkt_dispatcher: stimulus queues expected lane beats,
// a negedge monitor pops and compares every lane transfer.
module tb_pkt_dispatcher;

   localparam int NL = 2;
   localparam int DW = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        busy;
   logic [0:0]  active_lane;
   logic [31:0] pkt_count;
   logic [15:0] drop_count;

   int checks = 0;
   int errors = 0;
   int w;

   logic [9:0] q0[$];
   logic [9:0] q1[$];
   logic [9:0] mon_act;
   logic [9:0] mon_exp;

   pkt_dispatcher_if #(.NUM_LANES(NL), .DATA_W(DW)) bus();

   pkt_dispatcher #(.NUM_LANES(NL), .DATA_W(DW)) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .bus(bus),
      .busy(busy),
      .active_lane(active_lane),
      .pkt_count(pkt_count),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expectBeat(input int lane, input logic sop, input logic eop, input logic [7:0] d);
      if (lane == 0) q0.push_back({sop, eop, d});
      else           q1.push_back({sop, eop, d});
   endtask

   // Drives one byte, waits (bounded) for in_ready, returns just after the accepting edge.
   task automatic applyStimulus(input logic [7:0] d, input logic sop, input logic eop,
                                input bit disp, input int lane, output int waited);
      bus.in_data  = d;
      bus.in_sop   = sop;
      bus.in_eop   = eop;
      bus.in_valid = 1'b1;
      waited       = 0;
      if (disp) expectBeat(lane, sop, eop, d);
      @(negedge clk);
      while (!bus.in_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL in_ready timeout: got 0 expected 1");
      end
      @(posedge clk);
      #1;
      if (disp) checkOutput("lane_valid one cycle after accept", 32'(bus.lane_valid[lane]), 32'd1);
   endtask

   task automatic idleBus(input int n);
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendPkt4(input int lane);
      int wt;
      applyStimulus(8'hAA, 1'b1, 1'b0, 1'b1, lane, wt);
      checkOutput("busy after sop", 32'(busy), 32'd1);
      checkOutput("active_lane after sop", 32'(active_lane), 32'(lane));
      applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, lane, wt);
      applyStimulus(8'h02, 1'b0, 1'b0, 1'b1, lane, wt);
      applyStimulus(8'hBB, 1'b0, 1'b1, 1'b1, lane, wt);
      checkOutput("busy after eop", 32'(busy), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int i = 0; i < NL; i++) begin
            if (bus.lane_valid[i] && !bus.lane_stall[i]) begin
               mon_act = {bus.lane_sop[i], bus.lane_eop[i], bus.lane_data[i*DW +: DW]};
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected beat lane %0d: got %0h expected none", i, mon_act);
               end else begin
                  mon_exp = (i == 0) ? q0.pop_front() : q1.pop_front();
                  checkOutput($sformatf("lane%0d beat", i), 32'(mon_act), 32'(mon_exp));
               end
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst            = 1'b1;
      enable         = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_sop     = 1'b0;
      bus.in_eop     = 1'b0;
      bus.in_data    = '0;
      bus.lane_stall = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("reset lane_valid", 32'(bus.lane_valid), 32'd0);
      checkOutput("reset lane_sop", 32'(bus.lane_sop), 32'd0);
      checkOutput("reset lane_eop", 32'(bus.lane_eop), 32'd0);
      checkOutput("reset lane_data", 32'(bus.lane_data), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset active_lane", 32'(active_lane), 32'd0);
      checkOutput("reset pkt_count", pkt_count, 32'd0);
      checkOutput("reset drop_count", 32'(drop_count), 32'd0);
      rst = 1'b0;
      idleBus(1);

      // Two back-to-back packets alternate lanes
      sendPkt4(0);
      idleBus(2);
      sendPkt4(1);
      idleBus(3);
      checkOutput("pkt_count after two", pkt_count, 32'd2);

      // Disabled dispatch holds off sop bytes
      enable       = 1'b0;
      bus.in_data  = 8'h77;
      bus.in_sop   = 1'b1;
      bus.in_eop   = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      checkOutput("in_ready with enable=0", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      checkOutput("busy with enable=0", 32'(busy), 32'd0);
      bus.in_valid = 1'b0;
      enable       = 1'b1;
      idleBus(1);

      // Mid-packet stall on lane 0 for five cycles
      applyStimulus(8'hAA, 1'b1, 1'b0, 1'b1, 0, w);
      applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 0, w);
      bus.lane_stall[0] = 1'b1;
      fork
         applyStimulus(8'h02, 1'b0, 1'b0, 1'b1, 0, w);
         begin
            @(negedge clk);
            checkOutput("held lane0 data", 32'(bus.lane_data[7:0]), 32'h01);
            repeat (5) @(posedge clk);
            #1;
            bus.lane_stall[0] = 1'b0;
         end
      join
      checkOutput("stall wait cycles", 32'(w), 32'd5);
      applyStimulus(8'hBB, 1'b0, 1'b1, 1'b1, 0, w);
      idleBus(3);

      // Lane 1 stalled: next sop falls back to lane 0
      bus.lane_stall[1] = 1'b1;
      applyStimulus(8'h33, 1'b1, 1'b1, 1'b1, 0, w);
      checkOutput("skip stalled lane", 32'(active_lane), 32'd0);
      checkOutput("skip stalled lane wait", 32'(w), 32'd0);
      bus.lane_stall = 2'b11;
      fork
         applyStimulus(8'h44, 1'b1, 1'b1, 1'b1, 1, w);
         begin
            repeat (4) @(posedge clk);
            #1;
            bus.lane_stall[1] = 1'b0;
         end
      join
      checkOutput("all-stalled wait cycles", 32'(w), 32'd4);
      checkOutput("dispatch after unstall", 32'(active_lane), 32'd1);
      bus.lane_stall[0] = 1'b0;
      idleBus(3);
      checkOutput("pkt_count after five", pkt_count, 32'd5);

      // Out-of-packet bytes are dropped and counted with saturation
      applyStimulus(8'h10, 1'b0, 1'b0, 1'b0, 0, w);
      applyStimulus(8'h11, 1'b0, 1'b1, 1'b0, 0, w);
      applyStimulus(8'h12, 1'b0, 1'b0, 1'b0, 0, w);
      idleBus(2);
      checkOutput("drop_count three", 32'(drop_count), 32'd3);
      bus.in_data  = 8'h55;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
      bus.in_valid = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      idleBus(1);
      checkOutput("drop_count saturated", 32'(drop_count), 32'h0000FFFF);

      // Single-byte packets never enter BUSY
      applyStimulus(8'h5A, 1'b1, 1'b1, 1'b1, 0, w);
      checkOutput("single-byte busy", 32'(busy), 32'd0);
      checkOutput("single-byte lane", 32'(active_lane), 32'd0);
      idleBus(2);
      applyStimulus(8'h5B, 1'b1, 1'b1, 1'b1, 1, w);
      checkOutput("next packet lane", 32'(active_lane), 32'd1);
      idleBus(3);
      checkOutput("pkt_count after seven", pkt_count, 32'd7);

      // Reset in the middle of a packet flushes everything
      applyStimulus(8'hAA, 1'b1, 1'b0, 1'b1, 0, w);
      applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 0, w);
      rst = 1'b1;
      q0.delete();
      q1.delete();
      #1;
      checkOutput("mid reset lane_valid", 32'(bus.lane_valid), 32'd0);
      checkOutput("mid reset lane_data", 32'(bus.lane_data), 32'd0);
      checkOutput("mid reset busy", 32'(busy), 32'd0);
      checkOutput("mid reset in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("mid reset pkt_count", pkt_count, 32'd0);
      checkOutput("mid reset drop_count", 32'(drop_count), 32'd0);
      checkOutput("mid reset active_lane", 32'(active_lane), 32'd0);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idleBus(2);
      checkOutput("no valid after reset", 32'(bus.lane_valid), 32'd0);
      sendPkt4(0);
      idleBus(3);
      checkOutput("pkt_count after reset", pkt_count, 32'd1);
      checkOutput("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pkt_dispatcher.md
PKT_DISPATCHER -- requirements
Module: pkt_dispatcher

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2, number of matcher lanes sharing the input stream (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, symbol width in bits.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, 1 = new packets may be dispatched.
REQ-006 SHALL have port in_data, input, DATA_W, Avalon-ST sink symbol.
REQ-007 SHALL have ports in_valid, in_sop, in_eop, input, 1 each, Avalon-ST sink qualifiers.
REQ-008 SHALL have port in_ready, output, 1, Avalon-ST sink ready (readyLatency 0).
REQ-009 SHALL have port lane_data, output, NUM_LANES*DATA_W, per-lane symbol; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have ports lane_valid, lane_sop, lane_eop, output, NUM_LANES each, per-lane HLS call qualifiers.
REQ-011 SHALL have port lane_stall, input, NUM_LANES, per-lane HLS stall (1 = not accepting).
REQ-012 SHALL have port busy, output, 1, 1 while a packet is locked to a lane.
REQ-013 SHALL have port active_lane, output, $clog2(NUM_LANES), currently or last locked lane.
REQ-014 SHALL have port pkt_count, output, 32, packets dispatched (wraps at 2^32).
REQ-015 SHALL have port drop_count, output, 16, bytes discarded outside packets (saturates at 16'hFFFF).

Function
REQ-016 SHALL implement FSM states IDLE and BUSY.
REQ-017 Transfer on sink SHALL occur when in_valid && in_ready; transfer on lane i when lane_valid[i] && !lane_stall[i].
REQ-018 Each lane SHALL have a one-entry output register; lane_valid[i] holds, and lane_data/sop/eop stay stable, while lane_stall[i]=1.
REQ-019 Latency from sink transfer to lane_valid assertion SHALL be exactly 1 cycle.
REQ-020 In IDLE with enable=1 and in_valid && in_sop, SHALL select the first lane after the round-robin pointer whose output register is empty and lane_stall=0; transfer that byte to it; set pointer and active_lane to it; pkt_count+1.
REQ-021 In IDLE, if no lane qualifies or enable=0, in_ready SHALL be 0 for sop bytes.
REQ-022 In IDLE, a valid byte with in_sop=0 SHALL be accepted (in_ready=1) and discarded; drop_count+1 (saturating).
REQ-023 After a dispatched sop byte with in_eop=0, SHALL enter BUSY; with in_eop=1 (single-byte packet), SHALL stay IDLE.
REQ-024 In BUSY, in_ready SHALL be 1 iff the locked lane's register is empty or transferring this cycle; accepted bytes go only to the locked lane.
REQ-025 In BUSY, transfer of a byte with in_eop=1 SHALL return FSM to IDLE next cycle.
REQ-026 In BUSY, a byte with in_sop=1 SHALL be forwarded unchanged to the locked lane; no re-arbitration until eop.
REQ-027 enable deassertion in BUSY SHALL not abort the packet; it takes effect in IDLE only.
REQ-028 Lanes not locked SHALL keep lane_valid=0 except to drain an already-loaded register.
REQ-029 busy SHALL equal (state==BUSY); in_ready SHALL be combinational from state, registers, lane_stall, enable, in_sop.

Reset
REQ-030 On rst=1, SHALL asynchronously set state=IDLE, all lane_valid/lane_sop/lane_eop=0, lane_data=0, in_ready=0, busy=0, pointer=NUM_LANES-1 (first packet to lane 0), active_lane=0, pkt_count=0, drop_count=0.
REQ-031 rst mid-packet SHALL discard the partial packet and any lane register contents; no lane_valid after release until a new sop is dispatched.

Verification
REQ-032 Two 4-byte packets {AA,01,02,BB}, stalls 0 -> packet 1 on lane 0, packet 2 on lane 1, each byte 1 cycle after acceptance, pkt_count=2.
REQ-033 Lane 0 stall=1 for 5 cycles mid-packet -> in_ready=0 for those cycles, lane_data[0] held, no byte lost or duplicated, no bytes on lane 1.
REQ-034 Pointer at lane 0, lane 1 stalled, new sop -> dispatched to lane 0; all lanes stalled -> in_ready=0 until one clears.
REQ-035 Three bytes with sop=0 in IDLE -> accepted, no lane_valid, drop_count=3; 70000 such bytes -> drop_count=16'hFFFF.
REQ-036 Single-byte packet sop=eop=1 (data 5A) -> lane 0 gets 5A with sop=eop=1, busy stays 0, next packet goes to lane 1.
REQ-037 rst asserted after 2 of 4 bytes -> all outputs at reset values immediately; next packet goes to lane 0, pkt_count=1.
